// File: rtl/sdpram_burst_reader.sv
// Burst read master for a simple dual-port RAM: sequential port-B reads,
// latency absorption and a credit-limited valid/ready output stream.
module sdpram_burst_reader #(
    parameter int RAM_WIDTH    = 8,
    parameter int RAM_DEPTH    = 128,
    parameter int RAM_DWIDTH   = $clog2(RAM_DEPTH),
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  initial_done,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [RAM_DWIDTH-1:0] cmd_addr,
    input  logic [RAM_DWIDTH:0]   cmd_len,
    output logic [RAM_DWIDTH-1:0] addrb,
    output logic                  enb,
    input  logic [RAM_WIDTH-1:0]  doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RAM_WIDTH-1:0]  m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int BUF_DEPTH = READ_LATENCY + 2;
    localparam int CW        = $clog2(BUF_DEPTH + 1);
    localparam int PW        = $clog2(BUF_DEPTH);
    localparam logic [CW:0]   BUF_LIM = (CW+1)'(BUF_DEPTH);
    localparam logic [PW-1:0] PTR_TOP = PW'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        WAIT_INIT,
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state, state_n;

    logic [RAM_DWIDTH-1:0]   addr_q;
    logic [RAM_DWIDTH:0]     rem_q;
    logic [CW-1:0]           inflight_q;
    logic [CW-1:0]           count_q;
    logic [READ_LATENCY-1:0] vld_sr;
    logic [READ_LATENCY-1:0] last_sr;
    logic [RAM_WIDTH-1:0]    mem_d [BUF_DEPTH];
    logic                    mem_l [BUF_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;

    logic cmd_fire;
    logic issue;
    logic issue_last;
    logic cap;
    logic cap_last;
    logic pop;

    assign cmd_fire   = cmd_valid & cmd_ready & (state == IDLE);
    // A read may only launch if its word is guaranteed a buffer slot.
    assign issue      = (state == ISSUE) &&
                        (({1'b0, inflight_q} + {1'b0, count_q}) < BUF_LIM);
    assign issue_last = issue && (rem_q == (RAM_DWIDTH+1)'(1));
    assign cap        = vld_sr[READ_LATENCY-1];
    assign cap_last   = last_sr[READ_LATENCY-1];
    assign pop        = m_valid & m_ready;

    assign enb     = issue;
    assign addrb   = addr_q;
    assign busy    = (state == ISSUE) || (state == DRAIN);
    assign m_valid = (count_q != '0);
    assign m_data  = mem_d[rd_ptr];
    assign m_last  = mem_l[rd_ptr];

    always_comb begin
        state_n = state;
        unique case (state)
            WAIT_INIT: if (initial_done) state_n = IDLE;
            IDLE:      if (cmd_fire && (cmd_len != '0)) state_n = ISSUE;
            ISSUE:     if (issue_last) state_n = DRAIN;
            DRAIN:     if (pop && m_last) state_n = IDLE;
            default:   state_n = WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_INIT;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_ready <= (state_n == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else if (cmd_fire) begin
            addr_q <= cmd_addr;
            rem_q  <= cmd_len;
        end else if (issue) begin
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
        end
    end

    // Read tracking: the tap lines up with doutb for each issued read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr     <= '0;
            last_sr    <= '0;
            inflight_q <= '0;
            count_q    <= '0;
        end else begin
            vld_sr     <= (vld_sr << 1) | READ_LATENCY'(issue);
            last_sr    <= (last_sr << 1) | READ_LATENCY'(issue_last);
            inflight_q <= inflight_q + CW'(issue) - CW'(cap);
            count_q    <= count_q + CW'(cap) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_d[i] <= '0;
                mem_l[i] <= 1'b0;
            end
        end else begin
            if (cap) begin
                mem_d[wr_ptr] <= doutb;
                mem_l[wr_ptr] <= cap_last;
                wr_ptr <= (wr_ptr == PTR_TOP) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_TOP) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdpram_burst_reader.sv
// Self-checking bench for sdpram_burst_reader: RAM model, random stimulus,
// queue-based reference of expected read addresses and stream beats.
module tb_sdpram_burst_reader;

    localparam int W  = 8;
    localparam int D  = 128;
    localparam int AW = 7;
    localparam int RL = 1;
    localparam int BD = RL + 2;

    logic          tb_clk = 1'b0;
    logic          rst;
    logic          initial_done;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic [AW-1:0] addrb;
    logic          enb;
    logic [W-1:0]  doutb;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          busy;

    always #5 tb_clk = ~tb_clk;

    sdpram_burst_reader #(
        .RAM_WIDTH   (W),
        .RAM_DEPTH   (D),
        .RAM_DWIDTH  (AW),
        .READ_LATENCY(RL)
    ) dut (
        .clk         (tb_clk),
        .rst         (rst),
        .initial_done(initial_done),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .addrb       (addrb),
        .enb         (enb),
        .doutb       (doutb),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy)
    );

    // RAM preloaded with data[i] = i + 1, one cycle read latency
    logic [W-1:0] ram [D];
    initial begin
        for (int i = 0; i < D; i++) ram[i] = W'(i + 1);
        doutb = '0;
    end
    always @(posedge tb_clk) if (enb) doutb <= ram[addrb];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    logic [AW-1:0] exp_addr [$];
    logic [W:0]    exp_beat [$];

    bit           rand_rdy = 1'b0;
    int           cyc = 0;
    int           hs_cyc = 0;
    bit           lat_pend = 1'b0;
    bit           stall_p = 1'b0;
    logic [W:0]   stall_v = '0;
    bit           last_p = 1'b0;
    int           outst = 0;
    int           max_out = 0;
    int           beats = 0;
    int           first_cyc = 0;
    int           last_cyc = 0;
    int           enb_cnt = 0;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge tb_clk);
            #1;
            m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge tb_clk) begin
        cyc++;
        if (!rst) begin
            stall_p  = 1'b0;
            last_p   = 1'b0;
            lat_pend = 1'b0;
            outst    = 0;
        end else begin
            if (last_p) chk("busy_fall", 32'(busy), 0);
            last_p = 1'b0;
            if (stall_p) begin
                chk("stall_valid", 32'(m_valid), 1);
                chk("stall_hold", 32'({m_last, m_data}), 32'(stall_v));
            end
            if (m_valid && lat_pend) begin
                chk("latency", 32'(cyc - hs_cyc), 3);
                lat_pend = 1'b0;
            end
            if (cmd_valid && cmd_ready && cmd_len != '0) begin
                hs_cyc   = cyc;
                lat_pend = 1'b1;
            end
            if (enb) begin
                enb_cnt++;
                if (exp_addr.size() == 0) chk("spur_enb", 1, 0);
                else chk("addrb", 32'(addrb), 32'(exp_addr.pop_front()));
            end
            if (m_valid && m_ready) begin
                if (exp_beat.size() == 0) chk("spur_beat", 1, 0);
                else chk("beat", 32'({m_last, m_data}),
                         32'(exp_beat.pop_front()));
                if (beats == 0) first_cyc = cyc;
                beats++;
                last_cyc = cyc;
                last_p   = m_last;
            end
            outst += int'(enb) - int'(m_valid && m_ready);
            if (outst > max_out) max_out = outst;
            stall_p = m_valid && !m_ready;
            stall_v = {m_last, m_data};
        end
    end

    task automatic send_cmd(input int a, input int len);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge tb_clk);
            #1;
            t++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(AW'((a + i) % D));
            exp_beat.push_back({(i == len - 1), W'(((a + i) % D) + 1)});
        end
        beats     = 0;
        max_out   = 0;
        cmd_addr  = AW'(a);
        cmd_len   = (AW+1)'(len);
        cmd_valid = 1'b1;
        @(posedge tb_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int len, input bit rate);
        int t = 0;
        while ((exp_beat.size() != 0 || busy) && t < 3000) begin
            @(posedge tb_clk);
            #1;
            t++;
        end
        chk("done", 32'(exp_beat.size() == 0 && !busy), 1);
        chk("beats", 32'(beats), 32'(len));
        chk("addr_left", 32'(exp_addr.size()), 0);
        chk("buf_bound", 32'(max_out <= BD), 1);
        if (rate) chk("no_bubble", 32'(last_cyc - first_cyc), 32'(len - 1));
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_enb", 32'(enb), 0);
        chk("rst_addrb", 32'(addrb), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bit bad;
        int e0;
        int len;
        int t;
        rst          = 1'b0;
        initial_done = 1'b0;
        cmd_valid    = 1'b0;
        cmd_addr     = '0;
        cmd_len      = '0;
        repeat (3) @(posedge tb_clk);
        #1;
        chk_reset_outs();
        rst = 1'b1;

        bad = 1'b0;
        repeat (50) begin
            @(posedge tb_clk);
            #1;
            if (cmd_ready || enb) bad = 1'b1;
        end
        chk("wait_init", 32'(bad), 0);
        initial_done = 1'b1;
        @(posedge tb_clk);
        #1;
        chk("ready_after_init", 32'(cmd_ready), 1);
        initial_done = 1'b0;

        send_cmd(0, 8);
        wait_done(8, 1'b1);

        send_cmd(124, 6);
        wait_done(6, 1'b1);

        rand_rdy = 1'b1;
        send_cmd(int'($urandom_range(0, D - 1)), D);
        wait_done(D, 1'b0);
        rand_rdy = 1'b0;

        e0 = enb_cnt;
        send_cmd(5, 0);
        bad = 1'b0;
        repeat (10) begin
            @(posedge tb_clk);
            #1;
            if (!cmd_ready || m_valid || busy) bad = 1'b1;
        end
        chk("len0_enb", 32'(enb_cnt - e0), 0);
        chk("len0_quiet", 32'(bad), 0);
        send_cmd(77, 1);
        wait_done(1, 1'b1);

        rand_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            len = int'($urandom_range(1, 40));
            send_cmd(int'($urandom_range(0, D - 1)), len);
            wait_done(len, 1'b0);
        end
        rand_rdy = 1'b0;

        send_cmd(10, 16);
        t = 0;
        while (beats < 3 && t < 100) begin
            @(posedge tb_clk);
            #1;
            t++;
        end
        chk("reach_beat3", 32'(beats), 3);
        rst = 1'b0;
        #1;
        chk_reset_outs();
        exp_addr.delete();
        exp_beat.delete();
        beats = 0;
        repeat (2) @(posedge tb_clk);
        #1;
        rst = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(posedge tb_clk);
            #1;
            if (cmd_ready || enb || m_valid) bad = 1'b1;
        end
        chk("rewait_init", 32'(bad), 0);
        initial_done = 1'b1;
        @(posedge tb_clk);
        #1;
        chk("ready_after_reinit", 32'(cmd_ready), 1);
        send_cmd(40, 4);
        wait_done(4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
